// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin sharing of one single-ported BRAM between
// NUM_CORES cores. One transaction is issued per cycle through a registered
// issue stage. A two-stage tag pipeline returns a one-hot completion strobe
// to the issuing core. Per-core saturating counters record contention stalls.
//
// Handshake: a core holds core_read/core_write (plus address and data) high
// until core_accept for that core is high. The request is consumed in that
// same cycle, and the core may present a new request in the next cycle.
// core_valid pulses for exactly one cycle, two cycles after the accept, for
// both reads and writes.
module shared_mem_arbiter #(
  parameter int NUM_CORES    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             core_read,
  input  logic [NUM_CORES-1:0]             core_write,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0] core_address,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_data_in,
  output logic [NUM_CORES-1:0]             core_accept,
  output logic [NUM_CORES-1:0]             core_valid,
  output logic [DATA_WIDTH-1:0]            core_data_out,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDRESS_BITS-1:0]          mem_address,
  output logic [DATA_WIDTH-1:0]            mem_data_in,
  input  logic [DATA_WIDTH-1:0]            mem_data_out,
  output logic [NUM_CORES*32-1:0]          stall_count
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0]        rr_ptr;
  logic [NUM_CORES-1:0]    request;
  logic [ADDRESS_BITS-1:0] addr_arr [NUM_CORES];
  logic [DATA_WIDTH-1:0]   data_arr [NUM_CORES];
  logic [31:0]             stall_q  [NUM_CORES];

  logic                    grant_valid;
  logic [PTR_W-1:0]        grant_idx;
  logic                    sel_write;
  logic [ADDRESS_BITS-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  // Tag pipeline: valid + issuing core index. Reads and writes are
  // acknowledged identically, so the access type is not carried.
  logic                    tag1_valid, tag2_valid;
  logic [PTR_W-1:0]        tag1_idx, tag2_idx;

  assign request = core_read | core_write;

  // Unpack the flat per-core buses into arrays indexed by core number
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
    assign addr_arr[i] = core_address[i*ADDRESS_BITS +: ADDRESS_BITS];
    assign data_arr[i] = core_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign stall_count[i*32 +: 32] = stall_q[i];
  end

  // Round-robin search starting at rr_ptr; the candidate index is reduced
  // modulo NUM_CORES so non-power-of-two core counts never go out of range
  always_comb begin
    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sel_write   = 1'b0;
    sel_addr    = '0;
    sel_data    = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(NUM_CORES)) cand_sum = cand_sum - (PTR_W+1)'(NUM_CORES);
      cand = cand_sum[PTR_W-1:0];
      if (!grant_valid && request[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        sel_write   = core_write[cand];
        sel_addr    = addr_arr[cand];
        sel_data    = data_arr[cand];
      end
    end
    if (reset) grant_valid = 1'b0;
  end

  // One-hot accept and completion strobes decoded from the indices
  always_comb begin
    core_accept = '0;
    core_valid  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_accept[i] = grant_valid && (grant_idx == PTR_W'(i));
      core_valid[i]  = tag2_valid && (tag2_idx == PTR_W'(i));
    end
  end

  assign core_data_out = mem_data_out;

  // Pointer advances past the granted core, wrapping at NUM_CORES-1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      if (grant_idx == PTR_W'(NUM_CORES-1)) rr_ptr <= '0;
      else                                  rr_ptr <= grant_idx + 1'b1;
    end
  end

  // Issue stage: enables follow the grant; address/data hold when idle.
  // A write wins over a read asserted in the same request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      mem_read  <= grant_valid && !sel_write;
      mem_write <= grant_valid && sel_write;
      if (grant_valid) begin
        mem_address <= sel_addr;
        mem_data_in <= sel_data;
      end
    end
  end

  // Tag pipeline aligned with the issue stage and the BRAM read latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag1_valid <= 1'b0;
      tag1_idx   <= '0;
      tag2_valid <= 1'b0;
      tag2_idx   <= '0;
    end else begin
      tag1_valid <= grant_valid;
      tag1_idx   <= grant_idx;
      tag2_valid <= tag1_valid;
      tag2_idx   <= tag1_idx;
    end
  end

  // Saturating per-core stall counters: requesting but not accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (request[i] && !core_accept[i] && (stall_q[i] != 32'hFFFF_FFFF))
          stall_q[i] <= stall_q[i] + 32'd1;
      end
    end
  end

endmodule
